spdif_encoder: RTL



---
 rtl/spdif_pkg.sv | 30 +++
 rtl/spdif_bmc_serializer.sv | 52 +++++
 rtl/spdif_encoder.sv | 95 +++++++++
 3 files changed

// File: rtl/spdif_pkg.sv
// spdif_pkg: constants, preamble types and subframe helpers shared by the S/PDIF encoder and decoder
package spdif_pkg;
  typedef enum logic [1:0] {PRE_TYPE_B, PRE_TYPE_M, PRE_TYPE_W} pre_type_e;
  localparam logic [7:0] PRE_B = 8'b1110_1000;
  localparam logic [7:0] PRE_M = 8'b1110_0010;
  localparam logic [7:0] PRE_W = 8'b1110_0100;
  localparam int SLOT_AUDIO_LO = 4;
  localparam int SLOT_V = 28;
  localparam int SLOT_U = 29;
  localparam int SLOT_C = 30;
  localparam int SLOT_P = 31;
  localparam int FRAMES_PER_BLOCK = 192;
  localparam int HALFCELLS_PER_SUB = 64;

  function automatic logic [7:0] pre_pattern(input pre_type_e t);
    return t == PRE_TYPE_B ? PRE_B : t == PRE_TYPE_M ? PRE_M : PRE_W;
  endfunction

  // Slots 0-3 are left zero; the serializer replaces them with the preamble.
  function automatic logic [31:0] build_subframe(input logic [23:0] audio, input logic v, input logic c);
    logic [31:0] w;
    w = '0;
    w[SLOT_AUDIO_LO +: 24] = audio;
    w[SLOT_V] = v;
    w[SLOT_U] = 1'b0;
    w[SLOT_C] = c;
    w[SLOT_P] = ^w[SLOT_C:SLOT_AUDIO_LO];
    return w;
  endfunction
endpackage

// File: rtl/spdif_bmc_serializer.sv
// spdif_bmc_serializer: emits one 64-half-cell subframe per word, preamble then biphase-mark data
module spdif_bmc_serializer
  import spdif_pkg::*;
(
  input  logic        clk_in,
  input  logic        resetb,
  input  logic        ena_i,
  input  logic        tick_i,
  input  logic [31:0] word_i,
  input  logic [1:0]  pre_i,
  output logic        tx_o,
  output logic        subframe_done_o
);
  localparam int HW = $clog2(HALFCELLS_PER_SUB);
  logic [HW-1:0] hc_q, hc_d;
  logic [31:0]   word_q, word_d;
  logic [7:0]    pre_q, pre_d, pat;
  logic          tx_q, tx_d, first, preamble, step;
  logic [4:0]    slot;

  assign first    = hc_q == '0;
  assign preamble = hc_q[HW-1:3] == '0;
  assign slot     = hc_q[HW-1:1];
  assign step     = ena_i & tick_i;
  // Preamble is stored already inverted when the line sits high before it.
  assign pat      = pre_pattern(pre_type_e'(pre_i)) ^ {8{tx_q}};

  always_comb begin
    hc_d   = !ena_i ? '0 : tick_i ? hc_q + 1'b1 : hc_q;
    word_d = step & first ? word_i : word_q;
    pre_d  = !step ? pre_q : first ? pat : pre_q << 1;
    tx_d   = !ena_i ? 1'b0 : !tick_i ? tx_q : first ? pat[7] : preamble ? pre_q[6] :
             hc_q[0] ? tx_q ^ word_q[slot] : ~tx_q;
  end

  always_ff @(posedge clk_in or negedge resetb) begin
    if (!resetb) begin
      hc_q   <= '0;
      word_q <= '0;
      pre_q  <= '0;
      tx_q   <= 1'b0;
    end else begin
      hc_q   <= hc_d;
      word_q <= word_d;
      pre_q  <= pre_d;
      tx_q   <= tx_d;
    end
  end

  assign tx_o            = tx_q;
  assign subframe_done_o = step & (hc_q == '1);
endmodule

// File: rtl/spdif_encoder.sv
// spdif_encoder: IEC 60958 consumer transmitter with a one-pair holding buffer and 192-frame blocks
module spdif_encoder
  import spdif_pkg::*;
#(
  parameter int          CLK_DIV = 8,
  parameter logic [31:0] CS_WORD = 32'h0000_0004
) (
  input  logic        clk_in,
  input  logic        resetb,
  input  logic        ena,
  input  logic [23:0] sample_left,
  input  logic [23:0] sample_right,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        tx_out,
  output logic        block_start,
  output logic        underrun
);
  localparam int DW = $clog2(CLK_DIV);
  logic [DW-1:0] div_q, div_d;
  logic [7:0]    frame_q, frame_d;
  logic [23:0]   buf_l_q, buf_l_d, buf_r_q, buf_r_d, right_q, right_d;
  logic          sub_q, sub_d, start_q, start_d, full_q, full_d, v_q, v_d;
  logic          bs_q, bs_d, ur_q, ur_d;
  logic          tick, load, accept, done, c_bit;
  logic [31:0]   word;
  logic [1:0]    pre;

  assign tick   = ena & (div_q == DW'(CLK_DIV - 1));
  assign load   = tick & start_q & ~sub_q;
  assign accept = sample_valid & ~full_q;
  assign c_bit  = frame_q < 8'd32 ? CS_WORD[frame_q[4:0]] : 1'b0;
  // The left word reads the holding buffer directly because it is latched on the same tick the buffer empties.
  assign word   = sub_q ? build_subframe(right_q, v_q, c_bit)
                        : build_subframe(full_q ? buf_l_q : '0, ~full_q, c_bit);
  assign pre    = sub_q ? PRE_TYPE_W : frame_q == 8'd0 ? PRE_TYPE_B : PRE_TYPE_M;

  always_comb begin
    div_d   = !ena | tick ? '0 : div_q + 1'b1;
    start_d = !ena | (tick ? done : start_q);
    sub_d   = ena & (sub_q ^ done);
    frame_d = !ena ? '0 : !(done & sub_q) ? frame_q :
              frame_q == 8'(FRAMES_PER_BLOCK - 1) ? '0 : frame_q + 1'b1;
    full_d  = load & full_q ? 1'b0 : accept ? 1'b1 : full_q;
    buf_l_d = accept ? sample_left : buf_l_q;
    buf_r_d = accept ? sample_right : buf_r_q;
    right_d = load ? (full_q ? buf_r_q : '0) : right_q;
    v_d     = load ? ~full_q : v_q;
    bs_d    = load & (frame_q == 8'd0);
    ur_d    = load & ~full_q;
  end

  always_ff @(posedge clk_in or negedge resetb) begin
    if (!resetb) begin
      div_q   <= '0;
      frame_q <= '0;
      sub_q   <= 1'b0;
      start_q <= 1'b1;
      full_q  <= 1'b0;
      buf_l_q <= '0;
      buf_r_q <= '0;
      right_q <= '0;
      v_q     <= 1'b0;
      bs_q    <= 1'b0;
      ur_q    <= 1'b0;
    end else begin
      div_q   <= div_d;
      frame_q <= frame_d;
      sub_q   <= sub_d;
      start_q <= start_d;
      full_q  <= full_d;
      buf_l_q <= buf_l_d;
      buf_r_q <= buf_r_d;
      right_q <= right_d;
      v_q     <= v_d;
      bs_q    <= bs_d;
      ur_q    <= ur_d;
    end
  end

  spdif_bmc_serializer u_ser (
    .clk_in          (clk_in),
    .resetb          (resetb),
    .ena_i           (ena),
    .tick_i          (tick),
    .word_i          (word),
    .pre_i           (pre),
    .tx_o            (tx_out),
    .subframe_done_o (done)
  );

  assign sample_ready = ~full_q;
  assign block_start  = bs_q;
  assign underrun     = ur_q;
endmodule
